// File: rtl/lv_abist_seq_if.sv
// lv_abist_seq_if -- bundle between the low-voltage analog BIST sequencer and
// its surroundings (register/fault logic, analog front end, per-item checkers).
//
// Signals:
//   i_bist_start   run request, level-sampled, acted on only when idle
//   i_bist_abort   abort request, effective in any state
//   i_cmp_flag     raw asynchronous comparator outputs, one bit per item
//   o_bist_en      one-hot-or-zero stimulus enables toward the front end
//   o_bist_busy    run in progress
//   o_bist_done    single-cycle pulse at run completion
//   o_bist_result  per-item result of the last completed run, 1 = pass
//   o_bist_fail    OR of the failing items, updated together with the result
//
// Modports:
//   master  the requesting side (drives start/abort and the comparator flags)
//   slave   the sequencer itself
interface lv_abist_seq_if #(
  parameter int ITEM_NUM = 3
);

  logic                i_bist_start;
  logic                i_bist_abort;
  logic [ITEM_NUM-1:0] i_cmp_flag;
  logic [ITEM_NUM-1:0] o_bist_en;
  logic                o_bist_busy;
  logic                o_bist_done;
  logic [ITEM_NUM-1:0] o_bist_result;
  logic                o_bist_fail;

  modport master (
    output i_bist_start,
    output i_bist_abort,
    output i_cmp_flag,
    input  o_bist_en,
    input  o_bist_busy,
    input  o_bist_done,
    input  o_bist_result,
    input  o_bist_fail
  );

  modport slave (
    input  i_bist_start,
    input  i_bist_abort,
    input  i_cmp_flag,
    output o_bist_en,
    output o_bist_busy,
    output o_bist_done,
    output o_bist_result,
    output o_bist_fail
  );

endinterface

// File: rtl/lv_abist_seq.sv
// lv_abist_seq -- sequencer for the low-voltage analog BIST.
//
// On a start request the sequencer walks the comparators in fixed order
// (bit 0 = lv_ov, bit 1 = lv_uv, bit 2 = otp). For each item it:
//   PRE   keeps all stimulus off for SETTLE_CYC cycles and expects the
//         comparator to be idle (a high flag here is a stuck-high fault),
//   STIM  drives the item's stimulus enable for at most WIN_CYC cycles and
//         waits for the comparator to trip (no trip is a no-response fault),
//   REL   removes the stimulus for SETTLE_CYC cycles and expects the
//         comparator to have recovered by the last cycle.
// After the last item a one-cycle DONE publishes the pass vector.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   bus      lv_abist_seq_if.slave: start/abort requests, raw comparator
//            flags in; stimulus enables, busy, done pulse, result and fail out
//
// Parameters:
//   CLK_M       clock cycles per microsecond
//   ITEM_NUM    number of BIST items
//   WIN_US      stimulus window per item in microseconds
//   SETTLE_CYC  length of the PRE and REL phases in cycles (>= 1)
module lv_abist_seq #(
  parameter int CLK_M      = 48,
  parameter int ITEM_NUM   = 3,
  parameter int WIN_US     = 70,
  parameter int SETTLE_CYC = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lv_abist_seq_if.slave bus
);

  localparam int WIN_CYC = WIN_US * CLK_M;
  localparam int CNT_TOP = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam int IDX_W   = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1;

  localparam logic [CNT_W-1:0]    WIN_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0]    SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_SAT  = '1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(ITEM_NUM - 1);
  localparam logic [ITEM_NUM-1:0] ITEM_ONE = ITEM_NUM'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_STIM,
    S_REL,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic [ITEM_NUM-1:0] err;

  logic [ITEM_NUM-1:0] sync_q1;
  logic [ITEM_NUM-1:0] flag_s;

  logic [ITEM_NUM-1:0] en_q;
  logic                busy_q;
  logic                done_q;
  logic [ITEM_NUM-1:0] result_q;
  logic                fail_q;

  logic [ITEM_NUM-1:0] idx_mask;
  logic                cur_flag;
  logic [ITEM_NUM-1:0] err_hit;
  logic [ITEM_NUM-1:0] err_rel;
  logic [CNT_W-1:0]    cnt_inc;

  // Two-flop synchronizer per comparator; the raw flags are asynchronous to
  // i_clk and every decision below uses flag_s only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q1 <= '0;
      flag_s  <= '0;
    end else begin
      sync_q1 <= bus.i_cmp_flag;
      flag_s  <= sync_q1;
    end
  end

  // Helpers for the item under test. The flag is picked through a mask so an
  // index can never select outside the vector. err_rel is the error vector as
  // it stands after the recovery check of the last REL cycle; DONE publishes
  // it on the same edge that records it. The counter saturates instead of
  // wrapping.
  always_comb begin
    idx_mask = ITEM_ONE << idx;
    cur_flag = |(flag_s & idx_mask);
    err_hit  = err | idx_mask;
    err_rel  = cur_flag ? err_hit : err;
    cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
  end

  // Sequencer FSM with registered outputs. Abort has priority over every
  // state and leaves result/fail untouched, so the last completed run stays
  // visible. The enable is loaded on the edge entering STIM so the first
  // STIM cycle already shows it, and cleared on the edge leaving STIM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      err      <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      fail_q   <= 1'b0;
    end else if (bus.i_bist_abort) begin
      state  <= S_IDLE;
      cnt    <= '0;
      en_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_bist_start) begin
            err    <= '0;
            idx    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_PRE;
          end
        end

        S_PRE: begin
          if (cur_flag) begin
            err <= err_hit;
          end
          if (cnt == SET_LAST) begin
            cnt   <= '0;
            en_q  <= idx_mask;
            state <= S_STIM;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // A trip seen on the last window cycle still counts as a trip.
        S_STIM: begin
          if (cur_flag) begin
            cnt   <= '0;
            en_q  <= '0;
            state <= S_REL;
          end else if (cnt == WIN_LAST) begin
            err   <= err_hit;
            cnt   <= '0;
            en_q  <= '0;
            state <= S_REL;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Only the final REL cycle is judged, giving the comparator the
        // whole settle time to fall back.
        S_REL: begin
          if (cnt == SET_LAST) begin
            cnt <= '0;
            err <= err_rel;
            if (idx == IDX_LAST) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= ~err_rel;
              fail_q   <= |err_rel;
              state    <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_PRE;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_bist_en     = en_q;
  assign bus.o_bist_busy   = busy_q;
  assign bus.o_bist_done   = done_q;
  assign bus.o_bist_result = result_q;
  assign bus.o_bist_fail   = fail_q;

endmodule

// File: tb/tb_lv_abist_seq.sv
// tb_lv_abist_seq -- bench for lv_abist_seq with CLK_M=1, WIN_US=10,
// SETTLE_CYC=4, ITEM_NUM=2.
//
// A flag model answers each stimulus enable according to a per-item mode:
// NORMAL rises dly cycles after its enable rose and falls rec cycles after
// it fell; TIED0/TIED1 hold the flag constant. A reference model derives the
// expected enable length, pass/fail and done cycle of each run from those
// rules and queues them; monitors pop and compare when the DUT drops an
// enable or pulses done.
module tb_lv_abist_seq;

  localparam int CLK_M  = 1;
  localparam int WIN_US = 10;
  localparam int SETTLE = 4;
  localparam int ITEMS  = 2;
  localparam int WIN    = WIN_US * CLK_M;

  typedef enum int {NORMAL, TIED0, TIED1} fmode_t;

  typedef struct {
    logic [ITEMS-1:0] result;
    logic             fail;
    int               cyc;
  } done_t;

  typedef struct {
    int item;
    int len;
  } en_t;

  logic i_clk = 1'b0;
  logic i_rst_n;

  lv_abist_seq_if #(.ITEM_NUM(ITEMS)) bus ();

  lv_abist_seq #(
    .CLK_M     (CLK_M),
    .ITEM_NUM  (ITEMS),
    .WIN_US    (WIN_US),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  fmode_t mode [ITEMS];
  int     dly  [ITEMS];
  int     rec  [ITEMS];
  int     hi_cnt [ITEMS] = '{default: 0};
  int     lo_cnt [ITEMS] = '{default: 1000};
  int     en_len [ITEMS] = '{default: 0};
  logic   prev_done = 1'b0;

  done_t done_q [$];
  en_t   en_q   [$];

  logic [ITEMS-1:0] exp_res  = '0;
  logic             exp_fail = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Comparator model, reacting to the enables the DUT presents.
  always @(negedge i_clk) begin
    for (int i = 0; i < ITEMS; i++) begin
      if (bus.o_bist_en[i]) begin
        hi_cnt[i] = hi_cnt[i] + 1;
        lo_cnt[i] = 0;
      end else begin
        lo_cnt[i] = lo_cnt[i] + 1;
        hi_cnt[i] = 0;
      end
      case (mode[i])
        TIED0: bus.i_cmp_flag[i] = 1'b0;
        TIED1: bus.i_cmp_flag[i] = 1'b1;
        default: begin
          if (bus.o_bist_en[i]) begin
            if (hi_cnt[i] - 1 >= dly[i]) bus.i_cmp_flag[i] = 1'b1;
          end else if (lo_cnt[i] - 1 >= rec[i]) begin
            bus.i_cmp_flag[i] = 1'b0;
          end
        end
      endcase
    end
  end

  // Enable monitor: one-hot-or-zero every cycle, and each high stretch is
  // compared with the next queued expectation when it ends.
  always @(negedge i_clk) begin
    checks = checks + 1;
    if ($countones(bus.o_bist_en) > 1) begin
      errors = errors + 1;
      $display("[TB] FAIL en_onehot got=%b required=at most one bit", bus.o_bist_en);
    end
    for (int i = 0; i < ITEMS; i++) begin
      if (bus.o_bist_en[i]) begin
        en_len[i] = en_len[i] + 1;
      end else if (en_len[i] > 0) begin
        checks = checks + 1;
        if (en_q.size() == 0) begin
          errors = errors + 1;
          $display("[TB] FAIL en_len unexpected pulse item=%0d got=%0d required=none", i, en_len[i]);
        end else begin
          en_t e;
          e = en_q.pop_front();
          if (e.item != i || e.len != en_len[i]) begin
            errors = errors + 1;
            $display("[TB] FAIL en_len got item=%0d len=%0d required item=%0d len=%0d",
                     i, en_len[i], e.item, e.len);
          end
        end
        en_len[i] = 0;
      end
    end
  end

  // Done monitor: pulse width, result, fail and arrival cycle.
  always @(negedge i_clk) begin
    if (bus.o_bist_done) begin
      done_cnt = done_cnt + 1;
      checks = checks + 1;
      if (prev_done) begin
        errors = errors + 1;
        $display("[TB] FAIL done_width got=2+ cycles required=1 cycle");
      end else if (done_q.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL done_unexpected got=1 required=0 at cycle %0d", cyc);
      end else begin
        done_t d;
        d = done_q.pop_front();
        if (bus.o_bist_result !== d.result || bus.o_bist_fail !== d.fail || cyc != d.cyc) begin
          errors = errors + 1;
          $display("[TB] FAIL done_check got result=%b fail=%b cycle=%0d required result=%b fail=%b cycle=%0d",
                   bus.o_bist_result, bus.o_bist_fail, cyc, d.result, d.fail, d.cyc);
        end
      end
    end
    prev_done = bus.o_bist_done;
  end

  function automatic int expLen(input int i);
    if (mode[i] == TIED1) return 1;
    if (mode[i] == TIED0) return WIN;
    return (dly[i] <= WIN - 3) ? dly[i] + 3 : WIN;
  endfunction

  function automatic logic expPass(input int i);
    return (mode[i] == NORMAL) && (dly[i] <= WIN - 3) && (rec[i] <= SETTLE - 3);
  endfunction

  task automatic checkVal(input string name, input int actual, input int required);
    checks = checks + 1;
    if (actual != required) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkOutput(input string name, input logic [ITEMS-1:0] en, input logic busy,
                             input logic done, input logic [ITEMS-1:0] res, input logic fail);
    logic [2*ITEMS+2:0] got;
    logic [2*ITEMS+2:0] req;
    got = {bus.o_bist_en, bus.o_bist_busy, bus.o_bist_done, bus.o_bist_result, bus.o_bist_fail};
    req = {en, busy, done, res, fail};
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got en/busy/done/result/fail=%b required=%b", name, got, req);
    end
  endtask

  task automatic setModes(input fmode_t m0, input int d0, input int r0,
                          input fmode_t m1, input int d1, input int r1);
    mode[0] = m0; dly[0] = d0; rec[0] = r0;
    mode[1] = m1; dly[1] = d1; rec[1] = r1;
    repeat (5) @(negedge i_clk);
  endtask

  // Issues a start at the current negedge. With expect_done the modelled
  // enable lengths and the done expectation are queued.
  task automatic applyStimulus(input bit expect_done);
    int total;
    logic [ITEMS-1:0] pass;
    total = 0;
    for (int i = 0; i < ITEMS; i++) begin
      total = total + 2 * SETTLE + expLen(i);
      pass[i] = expPass(i);
      if (expect_done) en_q.push_back(en_t'{i, expLen(i)});
    end
    if (expect_done) begin
      done_q.push_back(done_t'{pass, ~&pass, cyc + 1 + total});
      exp_res  = pass;
      exp_fail = ~&pass;
    end
    bus.i_bist_start = 1'b1;
    @(negedge i_clk);
    bus.i_bist_start = 1'b0;
    checkVal("busy_after_start", int'(bus.o_bist_busy), 1);
  endtask

  task automatic waitRunDone(input string name);
    int n;
    n = 0;
    while ((done_q.size() != 0 || en_q.size() != 0) && n < 600) begin
      @(negedge i_clk);
      n++;
    end
    checks = checks + 1;
    if (n >= 600) begin
      errors = errors + 1;
      $display("[TB] FAIL %s timeout got=pending required=run complete", name);
      done_q.delete();
      en_q.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic waitEn(input int item, input string name);
    int n;
    n = 0;
    while (!bus.o_bist_en[item] && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    checkVal(name, int'(bus.o_bist_en[item]), 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    i_rst_n = 1'b0;
    bus.i_bist_start = 1'b0;
    bus.i_bist_abort = 1'b0;
    bus.i_cmp_flag = '0;
    mode = '{NORMAL, NORMAL};
    dly = '{3, 3};
    rec = '{1, 1};

    repeat (3) @(negedge i_clk);
    checkOutput("reset_state", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    checkOutput("idle_state", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    $display("[TB] all items respond");
    setModes(NORMAL, 3, 1, NORMAL, 3, 1);
    applyStimulus(1);
    waitRunDone("pass_run");
    checkOutput("pass_run_out", 2'b00, 1'b0, 1'b0, exp_res, exp_fail);

    $display("[TB] item 1 never responds");
    setModes(NORMAL, 3, 1, TIED0, 0, 0);
    applyStimulus(1);
    waitRunDone("noresp_run");
    checkOutput("noresp_run_out", 2'b00, 1'b0, 1'b0, 2'b01, 1'b1);

    $display("[TB] item 0 stuck high");
    setModes(TIED1, 0, 0, NORMAL, 3, 1);
    applyStimulus(1);
    waitRunDone("stuck_run");
    checkOutput("stuck_run_out", 2'b00, 1'b0, 1'b0, 2'b10, 1'b1);

    $display("[TB] abort during item 1 stimulus");
    setModes(NORMAL, 3, 1, NORMAL, 3, 1);
    applyStimulus(1);
    waitRunDone("pre_abort_run");
    checkOutput("pre_abort_out", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    en_q.push_back(en_t'{0, 6});
    en_q.push_back(en_t'{1, 5});
    applyStimulus(0);
    waitEn(1, "abort_reach_stim");
    repeat (4) @(negedge i_clk);
    bus.i_bist_abort = 1'b1;
    @(negedge i_clk);
    bus.i_bist_abort = 1'b0;
    checkOutput("abort_next", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    d0 = done_cnt;
    repeat (40) @(negedge i_clk);
    checkVal("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_hold", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);

    $display("[TB] start and abort together");
    bus.i_bist_start = 1'b1;
    bus.i_bist_abort = 1'b1;
    @(negedge i_clk);
    bus.i_bist_start = 1'b0;
    bus.i_bist_abort = 1'b0;
    checkOutput("start_abort", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    repeat (3) @(negedge i_clk);
    checkOutput("start_abort_hold", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);

    $display("[TB] reset during stimulus");
    en_q.push_back(en_t'{0, 3});
    applyStimulus(0);
    waitEn(0, "reset_reach_stim");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_mid", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    i_rst_n = 1'b1;
    exp_res = '0;
    exp_fail = 1'b0;
    repeat (3) @(negedge i_clk);

    $display("[TB] reset glitch and second start while busy");
    setModes(NORMAL, 2, 0, NORMAL, 5, 1);
    d0 = done_cnt;
    applyStimulus(1);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    bus.i_bist_start = 1'b1;
    @(negedge i_clk);
    bus.i_bist_start = 1'b0;
    waitRunDone("glitch_run");
    repeat (40) @(negedge i_clk);
    checkVal("single_done", done_cnt - d0, 1);
    checkOutput("glitch_run_out", 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < ITEMS; i++) begin
        int pick;
        pick = $urandom_range(0, 9);
        mode[i] = (pick == 0) ? TIED0 : (pick == 1) ? TIED1 : NORMAL;
        dly[i] = $urandom_range(0, WIN + 1);
        rec[i] = $urandom_range(0, 2);
      end
      repeat (5) @(negedge i_clk);
      applyStimulus(1);
      waitRunDone("random_run");
      checkOutput("random_run_out", 2'b00, 1'b0, 1'b0, exp_res, exp_fail);
    end

    checkVal("scoreboard_empty", done_q.size() + en_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lv_abist_seq.md
# lv_abist_seq

Sequencer for the low-voltage analog BIST. On a start request it walks through N analog comparators in fixed order. For each one it checks that the comparator is idle, forces its BIST stimulus for a bounded window, waits for the comparator to trip, then releases the stimulus and checks recovery. It drives the per-item BIST enables toward the analog front end and the per-item checkers. When the run completes it publishes a pass/fail vector and a done pulse to the register/fault logic.

## Interface
Parameters:
- CLK_M, 48: clock cycles per µs, from the common parameter header.
- ITEM_NUM, 3: number of BIST items (bit 0 = lv_ov, bit 1 = lv_uv, bit 2 = otp).
- WIN_US, 70: stimulus window per item, in µs.
- SETTLE_CYC, 16: cycles of the pre-check and release phases; must be ≥ 1.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous active-low, sampled on posedge i_clk.
- i_bist_start  in  1  run request, level-sampled; acted on only in IDLE.
- i_bist_abort  in  1  abort request; takes effect in any state.
- i_cmp_flag  in  ITEM_NUM  raw asynchronous comparator outputs (e.g. lv_vsup_ov).
- o_bist_en  out  ITEM_NUM  one-hot-or-zero stimulus enables, registered.
- o_bist_busy  out  1  high from the cycle after start acceptance until DONE.
- o_bist_done  out  1  single-cycle pulse at run completion.
- o_bist_result  out  ITEM_NUM  per-item result of the last completed run; 1 = pass.
- o_bist_fail  out  1  OR-reduction of ~o_bist_result, registered together with it.

## Operation
- Each bit of i_cmp_flag passes through a 2-flop synchronizer. All checks below use the synchronized flag, called flag_s.
- WIN_CYC = WIN_US*CLK_M. The counter width is $clog2(max(WIN_CYC, SETTLE_CYC)+1). The counter saturates and never wraps.
- idx is a $clog2(ITEM_NUM)-wide item index. err is a working fail vector.
- State machine:
  - IDLE: if i_bist_start=1 and i_bist_abort=0, clear err, set idx=0, clear the counter, go to PRE.
  - PRE: o_bist_en=0 for SETTLE_CYC cycles. If flag_s[idx]=1 in any PRE cycle, set err[idx] (stuck-high). Then go to STIM.
  - STIM: o_bist_en[idx]=1, counter counts 0..WIN_CYC-1.
    - If flag_s[idx]=1 in a STIM cycle, the item has tripped: go to REL next cycle.
    - If the counter reaches WIN_CYC-1 without a trip, set err[idx] (no-response) and go to REL.
  - REL: o_bist_en=0 for SETTLE_CYC cycles. If flag_s[idx]=1 in the last REL cycle, set err[idx] (no-recovery). Then:
    - if idx=ITEM_NUM-1, go to DONE;
    - otherwise increment idx and go to PRE.
  - DONE: one cycle. o_bist_done=1, o_bist_result=~err, o_bist_fail=|err. Return to IDLE.
- i_bist_start while busy is ignored; there is no queuing.
- i_bist_abort=1 in any state:
  - next state IDLE; o_bist_en=0, o_bist_busy=0 next cycle;
  - no done pulse; o_bist_result and o_bist_fail are unchanged.
- Start and abort in the same IDLE cycle: abort wins and no run starts.
- Reset mid-run has the same effect as abort, plus outputs go to their reset values.
- Reset values: o_bist_en=0, o_bist_busy=0, o_bist_done=0, o_bist_result=0 (no pass recorded), o_bist_fail=0, synchronizers 0, state IDLE.

## Timing
- Start sampled in IDLE at edge t: PRE is entered and o_bist_busy=1 from t+1. PRE occupies cycles t+1..t+SETTLE_CYC.
- STIM's first cycle has o_bist_en[idx]=1 at the output. The raw flag rising in STIM cycle k is seen as flag_s in cycle k+2. The FSM leaves STIM on the following edge, so en stays high for k+3 cycles.
- A no-response item holds en high for exactly WIN_CYC cycles.
- An item whose flag reacts after D cycles (D ≤ WIN_CYC-3) takes 2*SETTLE_CYC + D + 3 cycles in total.
- o_bist_done, o_bist_result and o_bist_fail update on the same edge. o_bist_busy falls on that same edge.
- At most one o_bist_en bit is ever high. The en bits never toggle within a PRE or REL phase.

## Test plan
Bench parameters: CLK_M=1, WIN_US=10, SETTLE_CYC=4, ITEM_NUM=2.
- Reset then idle: all outputs 0. Pulse start. Flag model raises each flag 3 cycles after its en and drops it 1 cycle after en falls. Required: en[0] high 6 cycles, then en[1] high 6 cycles; done pulse at cycle 29 after start; result=2'b11, fail=0.
- Flag[1] tied 0: en[1] high exactly 10 cycles; result=2'b01, fail=1.
- Flag[0] tied 1: stuck-high detected in PRE and no-recovery detected in REL; result[0]=0; item 1 still runs; result=2'b10.
- Abort asserted on the 5th cycle of STIM for item 1, after a prior passing run: en=0 and busy=0 next cycle; no done pulse; result stays 2'b11. Start and abort in the same cycle: busy stays 0.
- Synchronous reset asserted mid-STIM: outputs are zero from the next edge. A reset glitch between clock edges has no effect. A second start during busy is ignored: exactly one done pulse is produced.
